uart_rx_fifo: RTL and testbench

//  8N1 UART receiver for the 6502 computer: the host->FPGA end of the serial link whose TX side
//  the system already drives. Samples the uart_rx pin, assembles bytes LSB first, buffers them in
//  a small first-word-fall-through FIFO read by the CPU I/O logic, and flags framing/overrun errors.

---
 rtl/uart_rx_fifo_if.sv | 19 +
 rtl/uart_rx_fifo.sv | 99 +++++++++
 tb/tb_uart_rx_fifo.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: serial input, FIFO read port and error flags of the UART receiver
//  rx         master->slave  serial line, idle high
//  rd_en      master->slave  pop FIFO head
//  clr_err    master->slave  clear sticky error flags
//  data       slave->master  FIFO head byte
//  data_valid slave->master  FIFO not empty
//  frame_err  slave->master  sticky framing error
//  overrun    slave->master  sticky overrun
interface uart_rx_fifo_if;
  logic       rx;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  modport master (output rx, rd_en, clr_err, input data, data_valid, frame_err, overrun);
  modport slave (input rx, rd_en, clr_err, output data, data_valid, frame_err, overrun);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with first-word-fall-through FIFO and sticky error flags
//  clk  system clock
//  rst  synchronous reset, active-high
//  bus  uart_rx_fifo_if.slave: rx, rd_en, clr_err in; data, data_valid, frame_err, overrun out
module uart_rx_fifo #(
  parameter int BAUD_DIV  = 218,
  parameter int FIFO_LOG2 = 2
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bitn, bitn_n;
  logic [7:0] sr, sr_n;
  logic s1, rx_s, tick, push, set_fe;
  logic fe, ov;
  logic [7:0] mem [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_LOG2:0] count;
  logic full, pop, do_push, set_ov;
  assign tick = cnt == '0;
  always_comb begin
    state_n = state;
    cnt_n = cnt - CW'(1);
    bitn_n = bitn;
    sr_n = sr;
    push = 1'b0;
    set_fe = 1'b0;
    unique case (state)
      WAIT_HIGH: state_n = rx_s ? IDLE : WAIT_HIGH;
      IDLE: if (!rx_s) begin
        state_n = START;
        cnt_n = HALF;
      end
      START: if (tick) begin
        state_n = rx_s ? IDLE : DATA;
        cnt_n = FULL;
        bitn_n = 3'd0;
      end
      DATA: if (tick) begin
        sr_n = {rx_s, sr[7:1]};
        bitn_n = bitn + 3'd1;
        cnt_n = FULL;
        state_n = bitn == 3'd7 ? STOP : DATA;
      end
      STOP: if (tick) begin
        state_n = rx_s ? IDLE : WAIT_HIGH;
        push = rx_s;
        set_fe = !rx_s;
      end
      default: state_n = WAIT_HIGH;
    endcase
  end
  // count MSB is set only at DEPTH, so it doubles as the full flag
  assign full = count[FIFO_LOG2];
  assign pop = bus.rd_en && count != '0;
  assign do_push = push && (!full || pop);
  assign set_ov = push && full && !pop;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      rx_s <= 1'b1;
      state <= WAIT_HIGH;
      cnt <= '0;
      bitn <= '0;
      sr <= '0;
      fe <= 1'b0;
      ov <= 1'b0;
      mem <= '{default: 8'h00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      s1 <= bus.rx;
      rx_s <= s1;
      state <= state_n;
      cnt <= cnt_n;
      bitn <= bitn_n;
      sr <= sr_n;
      fe <= set_fe || (fe && !bus.clr_err);
      ov <= set_ov || (ov && !bus.clr_err);
      if (do_push) mem[wr_ptr] <= sr;
      wr_ptr <= wr_ptr + FIFO_LOG2'(do_push);
      rd_ptr <= rd_ptr + FIFO_LOG2'(pop);
      count <= count + (FIFO_LOG2 + 1)'(do_push) - (FIFO_LOG2 + 1)'(pop);
    end
  end
  assign bus.data = mem[rd_ptr];
  assign bus.data_valid = count != '0;
  assign bus.frame_err = fe;
  assign bus.overrun = ov;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scoreboard bench for uart_rx_fifo at BAUD_DIV=16, depth 4
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  logic [7:0] q [$];
  logic dv_pre, dv_post;
  uart_rx_fifo_if bus ();
  uart_rx_fifo #(.BAUD_DIV(16), .FIFO_LOG2(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // one 8N1 frame; rx falls just after edge 0, the receiver pushes on edge 155
  task automatic send(input logic [7:0] b, input logic stop, input logic pop_at_push);
    bus.rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(16);
      bus.rx = b[i];
    end
    step(16);
    bus.rx = stop;
    step(10);
    dv_pre = bus.data_valid;
    bus.rd_en = pop_at_push;
    step(1);
    dv_post = bus.data_valid;
    bus.rd_en = 1'b0;
    if (pop_at_push && q.size() != 0) void'(q.pop_front());
    if (stop && q.size() < 4) q.push_back(b);
    step(5);
  endtask
  task automatic read_check(input string tag);
    logic [7:0] e;
    int n = 0;
    while (!bus.data_valid && n < 400) begin
      step(1);
      n++;
    end
    chk({tag, "_valid"}, bus.data_valid, 1'b1);
    e = q.size() != 0 ? q.pop_front() : 8'h00;
    chk(tag, bus.data, e);
    bus.rd_en = 1'b1;
    step(1);
    bus.rd_en = 1'b0;
  endtask
  task automatic clear_errors();
    bus.clr_err = 1'b1;
    step(1);
    bus.clr_err = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    bus.rx = 1'b1;
    bus.rd_en = 1'b0;
    bus.clr_err = 1'b0;
    step(3);
    rst = 1'b0;
    chk("rst_valid", bus.data_valid, 1'b0);
    chk("rst_data", bus.data, 8'h00);
    chk("rst_fe", bus.frame_err, 1'b0);
    chk("rst_ov", bus.overrun, 1'b0);
    step(4);
    send(8'h23, 1'b1, 1'b0);
    chk("t1_valid_154", dv_pre, 1'b0);
    chk("t1_valid_155", dv_post, 1'b1);
    chk("t1_fe", bus.frame_err, 1'b0);
    chk("t1_ov", bus.overrun, 1'b0);
    read_check("t1_data");
    chk("t1_empty", bus.data_valid, 1'b0);
    send(8'h0D, 1'b1, 1'b0);
    send(8'h0A, 1'b1, 1'b0);
    send(8'h60, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) read_check("t2_data");
    chk("t2_empty", bus.data_valid, 1'b0);
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0);
    chk("t3_ov_set", bus.overrun, 1'b1);
    for (int i = 0; i < 4; i++) read_check("t3_data");
    chk("t3_empty", bus.data_valid, 1'b0);
    clear_errors();
    chk("t3_ov_clr", bus.overrun, 1'b0);
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, 1'b0);
    send(8'h05, 1'b1, 1'b1);
    chk("t3_ov_pop", bus.overrun, 1'b0);
    for (int i = 0; i < 4; i++) read_check("t3_pop_data");
    chk("t3_pop_empty", bus.data_valid, 1'b0);
    send(8'h55, 1'b0, 1'b0);
    step(24);
    bus.rx = 1'b1;
    step(20);
    chk("t4_fe_set", bus.frame_err, 1'b1);
    chk("t4_no_push", bus.data_valid, 1'b0);
    send(8'hAA, 1'b1, 1'b0);
    read_check("t4_data");
    chk("t4_fe_sticky", bus.frame_err, 1'b1);
    clear_errors();
    chk("t4_fe_clr", bus.frame_err, 1'b0);
    bus.rx = 1'b0;
    step(5);
    bus.rx = 1'b1;
    step(40);
    chk("t5_valid", bus.data_valid, 1'b0);
    chk("t5_fe", bus.frame_err, 1'b0);
    chk("t5_ov", bus.overrun, 1'b0);
    send(8'h11, 1'b1, 1'b0);
    bus.rx = 1'b0;
    step(16);
    for (int i = 0; i < 5; i++) begin
      bus.rx = i[0];
      step(16);
    end
    bus.rx = 1'b0;
    step(8);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    bus.rx = 1'b1;
    q.delete();
    chk("t6_valid", bus.data_valid, 1'b0);
    chk("t6_data", bus.data, 8'h00);
    chk("t6_fe", bus.frame_err, 1'b0);
    chk("t6_ov", bus.overrun, 1'b0);
    step(30);
    send(8'h7E, 1'b1, 1'b0);
    read_check("t6_rx");
    chk("t6_empty", bus.data_valid, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
